lock_sequencer: RTL and testbench
=================================

// Module: lock_sequencer
// PURPOSE
//  Central controller for the keypad password lock. Consumes debounced key codes from the
//  keypad scanner, sequences 4-digit entry, compare, unlock, code change and lockout.
//  Drives the 4 BCD display digits, status LEDs and a buzzer request.
//  Sits between the keypad scanner and the display/buzzer drivers.
// PARAMETERS
//  DEFAULT_CODE  16'h1234       reset password, 4 BCD digits, MS digit first
//  MAX_TRIES     2'd3           consecutive failures before LOCKOUT (1..3)
//  OPEN_CYCLES   32'd250000000  OPEN hold time in clk cycles
//  FAIL_CYCLES   32'd50000000   FAIL indication time
//  LOCK_CYCLES   32'd500000000  LOCKOUT duration
//  BEEP_CYCLES   32'd2500000    key-click beep length
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous reset, active high
//  key_value   in   5   key code: 0-9 digit, 10 CLEAR, 11 ENTER, 12 CHANGE, others ignored
//  key_ready   in   1   high while a valid key is held; key_value stable while high
//  seg_d1..4   out  4   display digits, BCD; 4'hF = blank; d1 = first entered digit
//  led_open    out  1   high in OPEN
//  led_error   out  1   high in FAIL
//  led_lock    out  1   high in LOCKOUT
//  mode_change out  1   high in SET
//  bee_req     out  1   buzzer request, level
//  try_cnt     out  2   consecutive failed attempts
// BEHAVIOUR
//  Reset: state ENTRY; code <= DEFAULT_CODE; buffer cleared (count=0); all seg_d* = 4'hF;
//   all LEDs, mode_change, bee_req = 0; try_cnt = 0; timers = 0.
//  Key event: kr_d <= key_ready each cycle; event = key_ready & ~kr_d; key_value sampled in the
//   event cycle. Held keys give exactly one event. Results are visible 1 cycle after the event edge.
//  Buffer: digit with count<4 shifts in at seg_d[count+1] and count++. 5th+ digit is ignored.
//   CLEAR blanks all digits and sets count=0. Buffer is cleared on every state change.
//  Accepted key (any action taken) loads the beep timer with BEEP_CYCLES.
//   bee_req = beep timer != 0 OR state in {FAIL, LOCKOUT}.
//  States:
//   ENTRY: digits/CLEAR as above. ENTER, count==4: match -> OPEN, try_cnt=0; else -> FAIL, try_cnt++.
//     ENTER with count<4 is a failure (-> FAIL). CHANGE ignored.
//   FAIL: keys ignored; after FAIL_CYCLES -> LOCKOUT if try_cnt==MAX_TRIES else ENTRY.
//   LOCKOUT: keys ignored; after LOCK_CYCLES -> ENTRY, try_cnt=0.
//   OPEN: after OPEN_CYCLES -> ENTRY; CLEAR -> ENTRY at once; CHANGE -> SET; digits/ENTER ignored.
//   SET: digit entry as ENTRY; ENTER with count==4 -> code <= buffer, -> ENTRY;
//     ENTER with count<4 ignored (stay SET); CHANGE aborts -> ENTRY, code unchanged.
//  Timers: single 32-bit state timer, loaded on state entry, decremented each cycle; expiry at 1.
//  Simultaneous: timer expiry and key event in the same cycle -> expiry wins, key dropped (no beep).
//  rst mid-operation: everything returns to reset values next cycle, including a changed code.
//  try_cnt saturates at MAX_TRIES; never wraps.
// TESTING  (override OPEN=20, FAIL=10, LOCK=40, BEEP=3)
//  rst; keys 1,2,3,4,ENTER -> led_open 1 cycle after ENTER edge, try_cnt=0, ENTRY after 20 cycles.
//  keys 1,2,3,5,ENTER x3 -> try_cnt 1,2,3; after third FAIL led_lock=1, bee_req=1 for 40 cycles,
//   then ENTRY, try_cnt=0; keys during FAIL/LOCKOUT ignored, display stays blank.
//  Unlock, CHANGE, 9,8,7,6,ENTER -> mode_change pulse ends, 1,2,3,4,ENTER fails, 9,8,7,6 opens.
//  key_ready held high 50 cycles with value 7 -> exactly one digit (seg_d1=7), bee_req high 3 cycles.
//  Keys 1,2,3,4,5 -> seg_d1..4 = 1,2,3,4; CLEAR -> all 4'hF, count=0.
//  Key event on FAIL timer expiry cycle -> state ENTRY, key dropped; rst in SET -> code back to 1234.

Source files
------------

// File: rtl/lock_sequencer_if.sv
// Keypad-lock bus: keypad scanner input plus display, LED, buzzer and try-count outputs.
//
// key_value / key_ready follow level-valid semantics: key_ready is high for as long as a key
// is held and key_value is stable while it is high. There is no ready back-pressure. The
// consumer reacts only to the rising edge of key_ready, so a held key is one event.
//
// Signals
//   key_value   [4:0]  key code (0-9 digit, 10 CLEAR, 11 ENTER, 12 CHANGE, others ignored)
//   key_ready          key held / key_value valid
//   seg_d1..4   [3:0]  BCD display digits, 4'hF = blank, d1 = first entered digit
//   led_open           unlocked
//   led_error          wrong code indication
//   led_lock           lockout
//   mode_change        code-change mode
//   bee_req            buzzer request (level)
//   try_cnt     [1:0]  consecutive failed attempts
//
// Modports
//   master : keypad/test side, drives keys and observes outputs
//   slave  : lock_sequencer side
interface lock_sequencer_if;
    logic [4:0] key_value;
    logic       key_ready;
    logic [3:0] seg_d1;
    logic [3:0] seg_d2;
    logic [3:0] seg_d3;
    logic [3:0] seg_d4;
    logic       led_open;
    logic       led_error;
    logic       led_lock;
    logic       mode_change;
    logic       bee_req;
    logic [1:0] try_cnt;

    modport master (
        output key_value, key_ready,
        input  seg_d1, seg_d2, seg_d3, seg_d4,
        input  led_open, led_error, led_lock, mode_change, bee_req, try_cnt
    );

    modport slave (
        input  key_value, key_ready,
        output seg_d1, seg_d2, seg_d3, seg_d4,
        output led_open, led_error, led_lock, mode_change, bee_req, try_cnt
    );
endinterface

// File: rtl/lock_sequencer.sv
// Central controller for the keypad password lock. Turns debounced key codes into a
// 4-digit entry buffer, compares against the stored code, and sequences unlock, code
// change, failure indication and lockout. Drives the display digits, status LEDs and a
// buzzer request.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active high
//   bus        lock_sequencer_if.slave: key input, display/LED/buzzer/try-count outputs
//   state_dbg  current FSM state (0 ENTRY, 1 OPEN, 2 FAIL, 3 LOCKOUT, 4 SET)
module lock_sequencer #(
    parameter logic [15:0] DEFAULT_CODE = 16'h1234,
    parameter logic [1:0]  MAX_TRIES    = 2'd3,
    parameter logic [31:0] OPEN_CYCLES  = 32'd250000000,
    parameter logic [31:0] FAIL_CYCLES  = 32'd50000000,
    parameter logic [31:0] LOCK_CYCLES  = 32'd500000000,
    parameter logic [31:0] BEEP_CYCLES  = 32'd2500000
) (
    input  logic             clk,
    input  logic             rst,
    lock_sequencer_if.slave  bus,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_OPEN    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_SET     = 3'd4
    } state_t;

    localparam logic [4:0] KEY_CLEAR  = 5'd10;
    localparam logic [4:0] KEY_ENTER  = 5'd11;
    localparam logic [4:0] KEY_CHANGE = 5'd12;

    // Registered state
    state_t      state_q;
    logic [15:0] code_q;
    logic [3:0]  digit_q [0:3];
    logic [2:0]  count_q;
    logic [31:0] timer_q;
    logic [31:0] beep_q;
    logic [1:0]  try_q;
    logic        kr_d;
    logic        open_q;
    logic        error_q;
    logic        lock_q;
    logic        mode_q;
    logic        bee_q;

    // Next-state values
    state_t      state_n;
    logic [15:0] code_n;
    logic [3:0]  digit_n [0:3];
    logic [2:0]  count_n;
    logic [31:0] timer_n;
    logic [31:0] beep_n;
    logic [1:0]  try_n;
    logic        accept;
    logic        key_event;
    logic        expire;
    logic        is_digit;
    logic        buf_full;
    logic [15:0] buf_code;

    always_comb begin
        key_event = bus.key_ready & ~kr_d;
        is_digit  = (bus.key_value <= 5'd9);
        buf_full  = (count_q == 3'd4);
        buf_code  = {digit_q[0], digit_q[1], digit_q[2], digit_q[3]};
        // Only OPEN, FAIL and LOCKOUT ever load the timer, so a value of 1 is always
        // the last cycle of a timed state.
        expire    = (timer_q == 32'd1);

        state_n = state_q;
        code_n  = code_q;
        for (int i = 0; i < 4; i++) digit_n[i] = digit_q[i];
        count_n = count_q;
        try_n   = try_q;
        timer_n = (timer_q != 32'd0) ? timer_q - 32'd1 : 32'd0;
        beep_n  = (beep_q != 32'd0) ? beep_q - 32'd1 : 32'd0;
        accept  = 1'b0;

        // Expiry has priority: a key arriving on the expiry cycle is dropped.
        if (expire) begin
            case (state_q)
                ST_OPEN: state_n = ST_ENTRY;
                ST_FAIL: state_n = (try_q == MAX_TRIES) ? ST_LOCKOUT : ST_ENTRY;
                ST_LOCKOUT: begin
                    state_n = ST_ENTRY;
                    try_n   = 2'd0;
                end
                default: ;
            endcase
        end else if (key_event) begin
            case (state_q)
                ST_ENTRY, ST_SET: begin
                    if (is_digit) begin
                        if (!buf_full) begin
                            digit_n[count_q[1:0]] = bus.key_value[3:0];
                            count_n = count_q + 3'd1;
                            accept  = 1'b1;
                        end
                    end else if (bus.key_value == KEY_CLEAR) begin
                        for (int i = 0; i < 4; i++) digit_n[i] = 4'hF;
                        count_n = 3'd0;
                        accept  = 1'b1;
                    end else if (bus.key_value == KEY_ENTER) begin
                        if (state_q == ST_ENTRY) begin
                            // A short entry counts as a wrong code.
                            accept = 1'b1;
                            if (buf_full && (buf_code == code_q)) begin
                                state_n = ST_OPEN;
                                try_n   = 2'd0;
                            end else begin
                                state_n = ST_FAIL;
                                if (try_q < MAX_TRIES) try_n = try_q + 2'd1;
                            end
                        end else if (buf_full) begin
                            code_n  = buf_code;
                            state_n = ST_ENTRY;
                            accept  = 1'b1;
                        end
                    end else if ((bus.key_value == KEY_CHANGE) && (state_q == ST_SET)) begin
                        state_n = ST_ENTRY;
                        accept  = 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (bus.key_value == KEY_CLEAR) begin
                        state_n = ST_ENTRY;
                        accept  = 1'b1;
                    end else if (bus.key_value == KEY_CHANGE) begin
                        state_n = ST_SET;
                        accept  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (accept) beep_n = BEEP_CYCLES;

        // Every state change starts with an empty buffer and a freshly loaded timer.
        if (state_n != state_q) begin
            for (int i = 0; i < 4; i++) digit_n[i] = 4'hF;
            count_n = 3'd0;
            case (state_n)
                ST_OPEN:    timer_n = OPEN_CYCLES;
                ST_FAIL:    timer_n = FAIL_CYCLES;
                ST_LOCKOUT: timer_n = LOCK_CYCLES;
                default:    timer_n = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ENTRY;
            code_q  <= DEFAULT_CODE;
            for (int i = 0; i < 4; i++) digit_q[i] <= 4'hF;
            count_q <= 3'd0;
            timer_q <= 32'd0;
            beep_q  <= 32'd0;
            try_q   <= 2'd0;
            kr_d    <= 1'b0;
            open_q  <= 1'b0;
            error_q <= 1'b0;
            lock_q  <= 1'b0;
            mode_q  <= 1'b0;
            bee_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            code_q  <= code_n;
            for (int i = 0; i < 4; i++) digit_q[i] <= digit_n[i];
            count_q <= count_n;
            timer_q <= timer_n;
            beep_q  <= beep_n;
            try_q   <= try_n;
            kr_d    <= bus.key_ready;
            // Outputs are registered from the next state so they line up with state_q.
            open_q  <= (state_n == ST_OPEN);
            error_q <= (state_n == ST_FAIL);
            lock_q  <= (state_n == ST_LOCKOUT);
            mode_q  <= (state_n == ST_SET);
            bee_q   <= (beep_n != 32'd0) || (state_n == ST_FAIL) || (state_n == ST_LOCKOUT);
        end
    end

    assign bus.seg_d1      = digit_q[0];
    assign bus.seg_d2      = digit_q[1];
    assign bus.seg_d3      = digit_q[2];
    assign bus.seg_d4      = digit_q[3];
    assign bus.led_open    = open_q;
    assign bus.led_error   = error_q;
    assign bus.led_lock    = lock_q;
    assign bus.mode_change = mode_q;
    assign bus.bee_req     = bee_q;
    assign bus.try_cnt     = try_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Testbench for lock_sequencer: directed scenarios plus randomized key streams, checked
// cycle by cycle against a behavioural model of the lock rules.
module tb_lock_sequencer;

    localparam int OPEN_N = 20;
    localparam int FAIL_N = 10;
    localparam int LOCK_N = 40;
    localparam int BEEP_N = 3;
    localparam int MAX_T  = 3;
    localparam int DEF_CODE = 'h1234;

    localparam int M_ENTRY = 0;
    localparam int M_OPEN  = 1;
    localparam int M_FAIL  = 2;
    localparam int M_LOCK  = 3;
    localparam int M_SET   = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    lock_sequencer_if bus();

    lock_sequencer #(
        .DEFAULT_CODE(16'h1234),
        .MAX_TRIES   (2'd3),
        .OPEN_CYCLES (32'd20),
        .FAIL_CYCLES (32'd10),
        .LOCK_CYCLES (32'd40),
        .BEEP_CYCLES (32'd3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    // ---------------- reference model ----------------
    // Timed modes are tracked by absolute cycle deadlines; the entry buffer is a queue.
    int cyc = 0;
    int m_mode = M_ENTRY;
    int m_code = DEF_CODE;
    int m_buf[$];
    int m_tries = 0;
    int m_deadline = 0;
    int m_beep_end = 0;
    bit m_kr = 1'b0;

    logic [22:0] exp_q[$];
    int total = 0;
    int bad = 0;

    function automatic int buf_value();
        return (m_buf[0] << 12) | (m_buf[1] << 8) | (m_buf[2] << 4) | m_buf[3];
    endfunction

    task automatic m_goto(input int m);
        if (m != m_mode) begin
            m_buf.delete();
            m_mode = m;
            case (m)
                M_OPEN:  m_deadline = cyc + OPEN_N;
                M_FAIL:  m_deadline = cyc + FAIL_N;
                M_LOCK:  m_deadline = cyc + LOCK_N;
                default: m_deadline = 0;
            endcase
        end
    endtask

    task automatic model_key(input int v, output bit acc);
        acc = 1'b0;
        case (m_mode)
            M_ENTRY, M_SET: begin
                if (v <= 9) begin
                    if (m_buf.size() < 4) begin
                        m_buf.push_back(v);
                        acc = 1'b1;
                    end
                end else if (v == 10) begin
                    m_buf.delete();
                    acc = 1'b1;
                end else if (v == 11) begin
                    if (m_mode == M_ENTRY) begin
                        acc = 1'b1;
                        if (m_buf.size() == 4 && buf_value() == m_code) begin
                            m_tries = 0;
                            m_goto(M_OPEN);
                        end else begin
                            if (m_tries < MAX_T) m_tries++;
                            m_goto(M_FAIL);
                        end
                    end else if (m_buf.size() == 4) begin
                        acc = 1'b1;
                        m_code = buf_value();
                        m_goto(M_ENTRY);
                    end
                end else if (v == 12 && m_mode == M_SET) begin
                    acc = 1'b1;
                    m_goto(M_ENTRY);
                end
            end
            M_OPEN: begin
                if (v == 10) begin
                    acc = 1'b1;
                    m_goto(M_ENTRY);
                end else if (v == 12) begin
                    acc = 1'b1;
                    m_goto(M_SET);
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [22:0] expected_vec();
        logic [3:0] s [0:3];
        for (int i = 0; i < 4; i++) s[i] = (i < m_buf.size()) ? 4'(m_buf[i]) : 4'hF;
        return {s[0], s[1], s[2], s[3],
                m_mode == M_OPEN, m_mode == M_FAIL, m_mode == M_LOCK, m_mode == M_SET,
                (cyc < m_beep_end) || m_mode == M_FAIL || m_mode == M_LOCK,
                2'(m_tries)};
    endfunction

    always @(posedge clk) begin : model_blk
        bit ev;
        bit acc;
        int v;
        cyc++;
        ev  = bus.key_ready && !m_kr;
        v   = int'(bus.key_value);
        acc = 1'b0;
        if (rst) begin
            m_mode = M_ENTRY;
            m_code = DEF_CODE;
            m_buf.delete();
            m_tries = 0;
            m_deadline = 0;
            m_beep_end = 0;
            m_kr = 1'b0;
        end else begin
            m_kr = bus.key_ready;
            if ((m_mode == M_OPEN || m_mode == M_FAIL || m_mode == M_LOCK) && cyc == m_deadline) begin
                case (m_mode)
                    M_OPEN: m_goto(M_ENTRY);
                    M_FAIL: m_goto((m_tries == MAX_T) ? M_LOCK : M_ENTRY);
                    default: begin
                        m_tries = 0;
                        m_goto(M_ENTRY);
                    end
                endcase
            end else if (ev) begin
                model_key(v, acc);
            end
            if (acc) m_beep_end = cyc + BEEP_N;
        end
        exp_q.push_back(expected_vec());
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : mon_blk
        logic [22:0] e;
        logic [22:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.seg_d1, bus.seg_d2, bus.seg_d3, bus.seg_d4,
                 bus.led_open, bus.led_error, bus.led_lock, bus.mode_change,
                 bus.bee_req, bus.try_cnt};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs cyc=%0d got: seg=%h leds(o,e,l,m)=%b bee=%b try=%0d | want: seg=%h leds=%b bee=%b try=%0d (state_dbg=%0d)",
                         cyc, a[22:7], a[6:3], a[2], a[1:0], e[22:7], e[6:3], e[2], e[1:0], state_dbg);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int v, input int hold = 2);
        bus.key_value = 5'(v);
        bus.key_ready = 1'b1;
        repeat (hold) @(negedge clk);
        bus.key_ready = 1'b0;
        bus.key_value = 5'($urandom_range(0, 31));
        @(negedge clk);
    endtask

    task automatic enter_code(input int code);
        for (int i = 3; i >= 0; i--) press((code >> (4 * i)) & 15);
        press(11);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim_blk
        int guard;
        int r;
        bus.key_value = 5'd0;
        bus.key_ready = 1'b0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Correct code opens, then times out.
        enter_code('h1234);
        idle(25);

        // Three wrong codes: FAIL x3 then LOCKOUT; keys during FAIL/LOCKOUT ignored.
        for (int k = 0; k < 3; k++) begin
            enter_code('h1235);
            press(4);
            press(11);
            idle(12);
        end
        press(1);
        press(12);
        idle(45);

        // Change code to 9876.
        enter_code('h1234);
        press(12);
        enter_code('h9876);
        idle(3);
        enter_code('h1234);
        idle(12);
        enter_code('h9876);
        idle(25);

        // Held key gives a single digit.
        press(7, 50);
        press(10);

        // Fifth digit ignored, CLEAR blanks.
        for (int d = 1; d <= 5; d++) press(d);
        idle(2);
        press(10);
        idle(2);

        // Short ENTER fails; key event lands on the FAIL expiry cycle.
        press(11);
        guard = 0;
        while (!(m_mode == M_FAIL && cyc == m_deadline - 1) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            total++;
            bad++;
            $display("FAIL expiry_wait got: timeout after %0d cycles, want: FAIL deadline reached", guard);
        end
        press(5);
        idle(5);

        // Reset while in SET restores the default code.
        enter_code('h9876);
        press(12);
        press(1);
        press(1);
        pulse_rst();
        idle(2);
        enter_code('h1234);
        idle(25);

        // Randomized key streams.
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 60) == 0) pulse_rst();
            if (r < 2) begin
                enter_code(m_code);
            end else if (r == 2) begin
                idle($urandom_range(5, 45));
            end else if (r == 3) begin
                press(($urandom_range(0, 1) == 0) ? 12 : 10, $urandom_range(1, 4));
            end else begin
                press(($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 15), $urandom_range(1, 4));
            end
        end
        idle(50);

        total++;
        if (exp_q.size() > 1) begin
            bad++;
            $display("FAIL drain got: %0d pending, want: at most 1", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
